// File: rtl/vis_snapshot_trace.sv
// vis_snapshot_trace: captures whole visibility-bus snapshots into a small FIFO and streams them out one channel per word.
module vis_snapshot_trace #(
   parameter int NUM_CH = 20,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int PC_CH  = 16
) (
   input  logic                        HCLK,
   input  logic                        HRESET,
   input  logic [NUM_CH*DATA_W-1:0]    vis_bus,
   input  logic [1:0]                  cfg_mode,
   input  logic [DATA_W-1:0]           cfg_pc_match,
   input  logic                        trig_ext,
   input  logic                        arm,
   input  logic                        clear,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic [$clog2(NUM_CH)-1:0]   out_ch,
   output logic                        out_last,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        overflow,
   output logic                        armed
);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int PTR_W = $clog2(DEPTH);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_n;
   logic [DATA_W-1:0] mem [DEPTH][NUM_CH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [DATA_W-1:0] pc, prev_pc;
   logic [PTR_W:0]    count_n;
   logic              trig, full, pop, store, drop;
   assign pc = vis_bus[PC_CH*DATA_W +: DATA_W];
   // An arm pulse counts as armed in its own cycle so arm+trigger captures.
   always_comb begin
      trig      = (cfg_mode == 2'd1) ? ((armed | arm) & (trig_ext | (pc == cfg_pc_match))) :
                  (cfg_mode == 2'd2) ? (pc != prev_pc) : (cfg_mode == 2'd3);
      full      = count == (PTR_W+1)'(DEPTH);
      out_valid = state == SEND;
      out_last  = out_valid & (out_ch == CH_W'(NUM_CH-1));
      pop       = out_valid & out_ready & out_last;
      store     = trig & (~full | pop);
      drop      = trig & full & ~pop;
      count_n   = clear ? '0 : count + (PTR_W+1)'(store) - (PTR_W+1)'(pop);
      state_n   = (count_n != '0) ? SEND : IDLE;
      out_data  = out_valid ? mem[rd_ptr][out_ch] : '0;
   end
   always_ff @(posedge HCLK) begin
      if (!HRESET && !clear && store)
         for (int k = 0; k < NUM_CH; k++) mem[wr_ptr][k] <= vis_bus[k*DATA_W +: DATA_W];
   end
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state    <= IDLE;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         out_ch   <= '0;
         overflow <= 1'b0;
         armed    <= 1'b0;
         prev_pc  <= '0;
      end else begin
         prev_pc <= pc;
         state   <= state_n;
         count   <= count_n;
         if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            out_ch   <= '0;
            overflow <= 1'b0;
         end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (out_valid && out_ready) out_ch <= out_last ? '0 : out_ch + 1'b1;
            if (drop) overflow <= 1'b1;
            if (arm) armed <= 1'b1;
            else if (cfg_mode == 2'd1 && trig) armed <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_vis_snapshot_trace.sv
// tb_vis_snapshot_trace: directed scenarios for the snapshot trace buffer with hand-computed expectations.
module tb_vis_snapshot_trace;
   localparam int NUM_CH = 20;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   logic HCLK = 1'b0;
   logic HRESET = 1'b1;
   logic [NUM_CH*DATA_W-1:0] vis_bus = '0;
   logic [1:0] cfg_mode = 2'd0;
   logic [DATA_W-1:0] cfg_pc_match = 32'h100;
   logic trig_ext = 1'b0, arm = 1'b0, clear = 1'b0, out_ready = 1'b0;
   logic out_valid, out_last, overflow, armed;
   logic [DATA_W-1:0] out_data;
   logic [4:0] out_ch;
   logic [2:0] count;
   int n_cmp = 0, n_bad = 0;

   vis_snapshot_trace #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .PC_CH(16)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .vis_bus(vis_bus), .cfg_mode(cfg_mode),
      .cfg_pc_match(cfg_pc_match), .trig_ext(trig_ext), .arm(arm), .clear(clear),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
      .out_last(out_last), .count(count), .overflow(overflow), .armed(armed));

   always #5 HCLK = ~HCLK;

   task automatic step();
      @(negedge HCLK);
   endtask

   task automatic set_bus(input logic [31:0] base, input logic [31:0] pc);
      for (int k = 0; k < NUM_CH; k++) vis_bus[k*32 +: 32] = (k == 16) ? pc : base + 32'(k);
   endtask

   function automatic logic [31:0] wexp(input logic [31:0] base, input logic [31:0] pc, input int k);
      return (k == 16) ? pc : base + 32'(k);
   endfunction

   task automatic test_reset();
      HRESET = 1'b1; arm = 1'b1; clear = 1'b1; cfg_mode = 2'd3;
      step(); step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", out_data); end
      n_cmp++; if (out_ch !== 5'd0) begin n_bad++; $display("FAIL rst_ch got %0d want 0", out_ch); end
      n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_last got %b want 0", out_last); end
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", overflow); end
      n_cmp++; if (armed !== 1'b0) begin n_bad++; $display("FAIL rst_armed got %b want 0", armed); end
      arm = 1'b0; clear = 1'b0; cfg_mode = 2'd0; HRESET = 1'b0;
      step();
   endtask

   task automatic test_single_shot();
      cfg_mode = 2'd1; out_ready = 1'b0; set_bus(32'h1000, 32'h0); arm = 1'b1;
      step();
      arm = 1'b0;
      n_cmp++; if (armed !== 1'b1) begin n_bad++; $display("FAIL ss_armed got %b want 1", armed); end
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL ss_count0 got %0d want 0", count); end
      set_bus(32'h2000, 32'h100);
      step();
      set_bus(32'h3000, 32'h100);
      n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL ss_count1 got %0d want 1", count); end
      n_cmp++; if (armed !== 1'b0) begin n_bad++; $display("FAIL ss_disarm got %b want 0", armed); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ss_latency got %b want 1", out_valid); end
      out_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         n_cmp++; if (out_ch !== 5'(i)) begin n_bad++; $display("FAIL ss_ch got %0d want %0d", out_ch, i); end
         n_cmp++; if (out_data !== wexp(32'h2000, 32'h100, i)) begin n_bad++; $display("FAIL ss_data ch%0d got %h want %h", i, out_data, wexp(32'h2000, 32'h100, i)); end
         n_cmp++; if (out_last !== (i == NUM_CH-1)) begin n_bad++; $display("FAIL ss_last ch%0d got %b", i, out_last); end
         step();
      end
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL ss_drain got %0d want 0", count); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ss_idle got %b want 0", out_valid); end
      cfg_mode = 2'd0; out_ready = 1'b0;
   endtask

   task automatic test_arm_trigger();
      cfg_mode = 2'd1; set_bus(32'h4000, 32'h0); arm = 1'b1; trig_ext = 1'b1;
      step();
      arm = 1'b0; trig_ext = 1'b0; cfg_mode = 2'd0; clear = 1'b1;
      n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL at_count got %0d want 1", count); end
      n_cmp++; if (armed !== 1'b1) begin n_bad++; $display("FAIL at_armed got %b want 1", armed); end
      step();
      clear = 1'b0;
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL at_clear got %0d want 0", count); end
      n_cmp++; if (armed !== 1'b1) begin n_bad++; $display("FAIL at_clr_armed got %b want 1", armed); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL at_clr_valid got %b want 0", out_valid); end
   endtask

   task automatic test_overflow();
      cfg_mode = 2'd3; out_ready = 1'b0; set_bus(32'hB000, 32'hB00);
      repeat (6) step();
      cfg_mode = 2'd0;
      n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", count); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
      clear = 1'b1;
      step();
      clear = 1'b0;
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL ovf_clr_count got %0d want 0", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr_flag got %b want 0", overflow); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_clr_valid got %b want 0", out_valid); end
   endtask

   task automatic test_pc_change();
      logic [31:0] pcs [5] = '{32'h10, 32'h10, 32'h14, 32'h14, 32'h18};
      logic [31:0] eb [2] = '{32'h5200, 32'h5400};
      logic [31:0] ep [2] = '{32'h14, 32'h18};
      cfg_mode = 2'd0; set_bus(32'hA000, 32'h10);
      step();
      cfg_mode = 2'd2;
      for (int i = 0; i < 5; i++) begin
         set_bus(32'h5000 + 32'(i) * 32'h100, pcs[i]);
         step();
      end
      cfg_mode = 2'd0;
      n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL pc_count got %0d want 2", count); end
      out_ready = 1'b1;
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < NUM_CH; k++) begin
            n_cmp++; if (out_data !== wexp(eb[s], ep[s], k) || out_ch !== 5'(k)) begin n_bad++; $display("FAIL pc_word s%0d ch%0d got ch%0d %h want %h", s, k, out_ch, out_data, wexp(eb[s], ep[s], k)); end
            step();
         end
      out_ready = 1'b0;
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL pc_drain got %0d want 0", count); end
   endtask

   task automatic test_full_pop();
      logic [31:0] eb [5] = '{32'h6000, 32'h6100, 32'h6200, 32'h6300, 32'h7000};
      logic [31:0] ep [5] = '{32'h600, 32'h601, 32'h602, 32'h603, 32'h700};
      cfg_mode = 2'd3; out_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         set_bus(eb[s], ep[s]);
         step();
      end
      cfg_mode = 2'd0;
      n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fp_fill got %0d want 4", count); end
      out_ready = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
         n_cmp++; if (out_data !== wexp(eb[0], ep[0], k)) begin n_bad++; $display("FAIL fp_word0 ch%0d got %h want %h", k, out_data, wexp(eb[0], ep[0], k)); end
         if (k == NUM_CH-1) begin cfg_mode = 2'd3; set_bus(eb[4], ep[4]); end
         step();
      end
      cfg_mode = 2'd0;
      n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fp_count got %0d want 4", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fp_ovf got %b want 0", overflow); end
      for (int s = 1; s < 5; s++)
         for (int k = 0; k < NUM_CH; k++) begin
            n_cmp++; if (out_data !== wexp(eb[s], ep[s], k) || out_ch !== 5'(k)) begin n_bad++; $display("FAIL fp_word s%0d ch%0d got ch%0d %h want %h", s, k, out_ch, out_data, wexp(eb[s], ep[s], k)); end
            step();
         end
      out_ready = 1'b0;
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL fp_drain got %0d want 0", count); end
   endtask

   task automatic test_back_to_back_stall();
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int e = 0, cyc = 0;
      cfg_mode = 2'd3; out_ready = 1'b0; set_bus(32'h8000, 32'h800);
      step();
      cfg_mode = 2'd0;
      while (e < NUM_CH && cyc < 100) begin
         out_ready = pat[cyc % 4];
         n_cmp++; if (out_valid !== 1'b1 || out_ch !== 5'(e) || out_data !== wexp(32'h8000, 32'h800, e) || out_last !== (e == NUM_CH-1)) begin
            n_bad++; $display("FAIL stall cyc%0d got v%b ch%0d %h l%b want ch%0d %h", cyc, out_valid, out_ch, out_data, out_last, e, wexp(32'h8000, 32'h800, e));
         end
         step();
         if (out_ready) e++;
         cyc++;
      end
      out_ready = 1'b0;
      n_cmp++; if (e != NUM_CH) begin n_bad++; $display("FAIL stall_budget got %0d words want %0d", e, NUM_CH); end
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL stall_drain got %0d want 0", count); end
   endtask

   task automatic test_reset_mid();
      cfg_mode = 2'd3; out_ready = 1'b0; set_bus(32'h9000, 32'h900);
      step();
      cfg_mode = 2'd1; arm = 1'b1;
      step();
      arm = 1'b0; out_ready = 1'b1;
      repeat (7) step();
      n_cmp++; if (out_ch !== 5'd7 || armed !== 1'b1) begin n_bad++; $display("FAIL rm_pre got ch%0d armed%b want ch7 armed1", out_ch, armed); end
      HRESET = 1'b1;
      step();
      HRESET = 1'b0; out_ready = 1'b0; cfg_mode = 2'd0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid got %b want 0", out_valid); end
      n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rm_count got %0d want 0", count); end
      n_cmp++; if (armed !== 1'b0) begin n_bad++; $display("FAIL rm_armed got %b want 0", armed); end
      n_cmp++; if (out_ch !== 5'd0) begin n_bad++; $display("FAIL rm_ch got %0d want 0", out_ch); end
   endtask

   initial begin
      test_reset();
      test_single_shot();
      test_arm_trigger();
      test_overflow();
      test_pc_change();
      test_full_pop();
      test_back_to_back_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/vis_snapshot_trace.md
VIS_SNAPSHOT_TRACE -- requirements
Module: vis_snapshot_trace

Interface
REQ-001 SHALL take parameter NUM_CH, default 20: number of visibility channels per snapshot (2..32).
REQ-002 SHALL take parameter DATA_W, default 32: channel width in bits.
REQ-003 SHALL take parameter DEPTH, default 4: snapshot buffer depth (power of 2, >=2).
REQ-004 SHALL take parameter PC_CH, default 16: channel index compared for PC match and PC change.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 HCLK  in  1  sole clock, rising edge.
REQ-007 HRESET  in  1  synchronous active-high reset.
REQ-008 vis_bus  in  NUM_CH*DATA_W  packed channels; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 cfg_mode  in  2  0 off, 1 single-shot, 2 on-PC-change, 3 every-cycle.
REQ-010 cfg_pc_match  in  DATA_W  single-shot PC trigger value.
REQ-011 trig_ext  in  1  external single-shot trigger, level-sampled.
REQ-012 arm  in  1  one-cycle pulse; re-arms single-shot.
REQ-013 clear  in  1  one-cycle pulse; empties buffer, clears overflow.
REQ-014 out_valid  out  1  readout word valid.
REQ-015 out_ready  in  1  consumer accepts word.
REQ-016 out_data  out  DATA_W  channel value.
REQ-017 out_ch  out  clog2(NUM_CH)  channel index of out_data.
REQ-018 out_last  out  1  high with last channel of a snapshot.
REQ-019 count  out  clog2(DEPTH)+1  stored snapshots, including the one being read.
REQ-020 overflow  out  1  sticky: capture dropped because buffer full.
REQ-021 armed  out  1  single-shot armed.

Function
REQ-022 Capture SHALL write all NUM_CH channels of vis_bus atomically into one buffer entry at the rising edge of the capture cycle.
REQ-023 Mode 1: capture SHALL occur when armed=1 and (trig_ext=1 or channel PC_CH == cfg_pc_match); armed SHALL clear in that cycle; further triggers are ignored until arm.
REQ-024 Mode 2: capture SHALL occur when channel PC_CH differs from its value in the previous cycle; the previous-value register SHALL update every cycle in every mode.
REQ-025 Mode 3: capture SHALL occur every cycle.
REQ-026 Mode 0: no capture; readout of stored entries SHALL continue.
REQ-027 Capture with count==DEPTH and no same-cycle pop SHALL be dropped and set overflow; a single-shot trigger dropped this way SHALL still clear armed.
REQ-028 Capture with count==DEPTH and same-cycle pop (out_last accepted) SHALL be stored; overflow unchanged.
REQ-029 Readout FSM: IDLE -> SEND when count>0; in SEND out_valid=1, out_ch walks 0..NUM_CH-1, advancing only on out_valid&out_ready.
REQ-030 out_data/out_ch/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 Accepting the word with out_last=1 SHALL pop the entry, decrement count, reset out_ch to 0; FSM stays SEND if entries remain (no bubble), else IDLE.
REQ-032 First out_valid SHALL assert the cycle after the first capture into an empty buffer (latency 1).
REQ-033 Write/read pointers SHALL wrap modulo DEPTH; simultaneous capture and pop SHALL leave count unchanged.
REQ-034 clear SHALL take priority over capture and pop: next cycle count=0, out_valid=0, FSM IDLE, overflow=0; armed unchanged.
REQ-035 arm and a trigger in the same cycle SHALL capture and leave armed=1.

Reset
REQ-036 HRESET=1 SHALL give out_valid=0, out_data=0, out_ch=0, out_last=0, count=0, overflow=0, armed=0, pointers 0, previous-PC register 0, FSM IDLE.
REQ-037 HRESET SHALL override arm, clear and capture in the same cycle; a reset mid-readout SHALL discard the partial snapshot.

Verification
REQ-038 Mode 1, arm, channel 16=0x100 with cfg_pc_match=0x100 -> count=1, armed=0, 20 words out_ch 0..19 matching captured channels, out_last on ch 19.
REQ-039 Mode 3, out_ready=0 for 6 cycles, DEPTH=4 -> count=4, overflow=1; clear -> count=0, overflow=0.
REQ-040 Mode 2, PC sequence 0x10,0x10,0x14,0x14,0x18 -> exactly 2 captures, holding PC 0x14 and 0x18.
REQ-041 count=4, capture in the same cycle out_last accepted -> count stays 4, overflow=0, new snapshot read last.
REQ-042 out_ready toggled 1,0,0,1 mid-snapshot -> out_data/out_ch held during stall, no word skipped or duplicated.
REQ-043 HRESET asserted at out_ch=7 -> next cycle out_valid=0, count=0, armed=0.
